// File: rtl/axi_txn_arbiter_if.sv
// Bus bundles for the two-master AXI transaction arbiter: a two-lane master-side
// bus (lane i belongs to master i) and the single slave-side bus.

interface axi_txn_m_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int AP = ADDR_W + 13;
  localparam int WP = DATA_W + 1;
  localparam int RP = DATA_W + 3;

  logic [1:0]      m_arvalid;
  logic [2*AP-1:0] m_arpay;
  logic [1:0]      m_arready;

  logic [1:0]      m_rvalid;
  logic [RP-1:0]   m_rpay;
  logic [1:0]      m_rready;

  logic [1:0]      m_awvalid;
  logic [2*AP-1:0] m_awpay;
  logic [1:0]      m_awready;

  logic [1:0]      m_wvalid;
  logic [2*WP-1:0] m_wpay;
  logic [1:0]      m_wready;

  logic [1:0]      m_bvalid;
  logic [1:0]      m_bresp;
  logic [1:0]      m_bready;

  // The masters drive requests and data; the arbiter answers.
  modport master (
    output m_arvalid, m_arpay, m_rready, m_awvalid, m_awpay,
           m_wvalid, m_wpay, m_bready,
    input  m_arready, m_rvalid, m_rpay, m_awready, m_wready,
           m_bvalid, m_bresp
  );

  modport slave (
    input  m_arvalid, m_arpay, m_rready, m_awvalid, m_awpay,
           m_wvalid, m_wpay, m_bready,
    output m_arready, m_rvalid, m_rpay, m_awready, m_wready,
           m_bvalid, m_bresp
  );
endinterface

interface axi_txn_s_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int AP = ADDR_W + 13;
  localparam int WP = DATA_W + 1;
  localparam int RP = DATA_W + 3;

  logic          s_arvalid;
  logic [AP-1:0] s_arpay;
  logic          s_arready;

  logic          s_rvalid;
  logic [RP-1:0] s_rpay;
  logic          s_rready;

  logic          s_awvalid;
  logic [AP-1:0] s_awpay;
  logic          s_awready;

  logic          s_wvalid;
  logic [WP-1:0] s_wpay;
  logic          s_wready;

  logic          s_bvalid;
  logic [1:0]    s_bresp;
  logic          s_bready;

  // The arbiter is the master of the shared slave.
  modport master (
    output s_arvalid, s_arpay, s_rready, s_awvalid, s_awpay,
           s_wvalid, s_wpay, s_bready,
    input  s_arready, s_rvalid, s_rpay, s_awready, s_wready,
           s_bvalid, s_bresp
  );

  modport slave (
    input  s_arvalid, s_arpay, s_rready, s_awvalid, s_awpay,
           s_wvalid, s_wpay, s_bready,
    output s_arready, s_rvalid, s_rpay, s_awready, s_wready,
           s_bvalid, s_bresp
  );
endinterface

// File: rtl/axi_txn_arbiter.sv
// Two-master to one-slave AXI arbiter: grants the single-threaded slave to one
// master for a whole read or write transaction, round-robin with per-master R/W alternation.

module axi_txn_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic               aclk,
  input  logic               areset,
  axi_txn_m_if.slave         mbus,
  axi_txn_s_if.master        sbus,
  output logic [2:0]         status
);

  localparam int AP = ADDR_W + 13;
  localparam int WP = DATA_W + 1;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_AR   = 3'd1,
    ST_R    = 3'd2,
    ST_AW   = 3'd3,
    ST_W    = 3'd4,
    ST_B    = 3'd5
  } state_t;

  state_t        r_state;
  state_t        w_nextState;
  logic          r_owner;
  logic          r_last;
  logic [1:0]    r_prevWrite;

  logic [1:0]    w_req;
  logic          w_winner;
  logic          w_winAr;
  logic          w_winAw;
  logic          w_grantWrite;
  logic          w_grant;

  logic [1:0]    w_ownMask;
  logic          w_ownArvalid;
  logic [AP-1:0] w_ownArpay;
  logic          w_ownAwvalid;
  logic [AP-1:0] w_ownAwpay;
  logic          w_ownWvalid;
  logic [WP-1:0] w_ownWpay;
  logic          w_ownRready;
  logic          w_ownBready;
  logic          w_stateWrite;

  // Request sampling and the arbitration decision only matter in IDLE.
  assign w_req   = mbus.m_arvalid | mbus.m_awvalid;
  assign w_grant = (r_state == ST_IDLE) && (|w_req);

  always_comb begin
    w_winner = 1'b0;
    if (w_req[0] && w_req[1]) begin
      w_winner = ~r_last;
    end else if (w_req[1]) begin
      w_winner = 1'b1;
    end
  end

  assign w_winAr      = w_winner ? mbus.m_arvalid[1] : mbus.m_arvalid[0];
  assign w_winAw      = w_winner ? mbus.m_awvalid[1] : mbus.m_awvalid[0];
  assign w_grantWrite = (w_winAr && w_winAw) ? ~r_prevWrite[w_winner] : w_winAw;

  // Owner-lane views of every master-side input the slave path needs.
  assign w_ownMask    = r_owner ? 2'b10 : 2'b01;
  assign w_ownArvalid = r_owner ? mbus.m_arvalid[1] : mbus.m_arvalid[0];
  assign w_ownArpay   = r_owner ? mbus.m_arpay[2*AP-1:AP] : mbus.m_arpay[AP-1:0];
  assign w_ownAwvalid = r_owner ? mbus.m_awvalid[1] : mbus.m_awvalid[0];
  assign w_ownAwpay   = r_owner ? mbus.m_awpay[2*AP-1:AP] : mbus.m_awpay[AP-1:0];
  assign w_ownWvalid  = r_owner ? mbus.m_wvalid[1] : mbus.m_wvalid[0];
  assign w_ownWpay    = r_owner ? mbus.m_wpay[2*WP-1:WP] : mbus.m_wpay[WP-1:0];
  assign w_ownRready  = r_owner ? mbus.m_rready[1] : mbus.m_rready[0];
  assign w_ownBready  = r_owner ? mbus.m_bready[1] : mbus.m_bready[0];

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // last starts at 1 so master 0 wins the first tie; toggles start at write so read goes first.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_owner     <= 1'b0;
      r_last      <= 1'b1;
      r_prevWrite <= 2'b11;
    end else if (w_grant) begin
      r_owner               <= w_winner;
      r_last                <= w_winner;
      r_prevWrite[w_winner] <= w_grantWrite;
    end
  end

  // A transaction only ends on the last-beat handshake; len is never counted.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_IDLE: begin
        if (|w_req) begin
          w_nextState = w_grantWrite ? ST_AW : ST_AR;
        end
      end
      ST_AR: begin
        if (w_ownArvalid && sbus.s_arready) begin
          w_nextState = ST_R;
        end
      end
      ST_R: begin
        if (sbus.s_rvalid && w_ownRready && sbus.s_rpay[0]) begin
          w_nextState = ST_IDLE;
        end
      end
      ST_AW: begin
        if (w_ownAwvalid && sbus.s_awready) begin
          w_nextState = ST_W;
        end
      end
      ST_W: begin
        if (w_ownWvalid && sbus.s_wready && w_ownWpay[0]) begin
          w_nextState = ST_B;
        end
      end
      ST_B: begin
        if (sbus.s_bvalid && w_ownBready) begin
          w_nextState = ST_IDLE;
        end
      end
      default: w_nextState = ST_IDLE;
    endcase
  end

  // Everything is routed from the registered state, so IDLE never passes a request through.
  always_comb begin
    sbus.s_arvalid = 1'b0;
    sbus.s_arpay   = '0;
    sbus.s_rready  = 1'b0;
    sbus.s_awvalid = 1'b0;
    sbus.s_awpay   = '0;
    sbus.s_wvalid  = 1'b0;
    sbus.s_wpay    = '0;
    sbus.s_bready  = 1'b0;
    mbus.m_arready = 2'b00;
    mbus.m_rvalid  = 2'b00;
    mbus.m_awready = 2'b00;
    mbus.m_wready  = 2'b00;
    mbus.m_bvalid  = 2'b00;
    case (r_state)
      ST_AR: begin
        sbus.s_arvalid = w_ownArvalid;
        sbus.s_arpay   = w_ownArpay;
        mbus.m_arready = w_ownMask & {2{sbus.s_arready}};
      end
      ST_R: begin
        mbus.m_rvalid  = w_ownMask & {2{sbus.s_rvalid}};
        sbus.s_rready  = w_ownRready;
      end
      ST_AW: begin
        sbus.s_awvalid = w_ownAwvalid;
        sbus.s_awpay   = w_ownAwpay;
        mbus.m_awready = w_ownMask & {2{sbus.s_awready}};
      end
      ST_W: begin
        sbus.s_wvalid  = w_ownWvalid;
        sbus.s_wpay    = w_ownWpay;
        mbus.m_wready  = w_ownMask & {2{sbus.s_wready}};
      end
      ST_B: begin
        mbus.m_bvalid  = w_ownMask & {2{sbus.s_bvalid}};
        sbus.s_bready  = w_ownBready;
      end
      default: ;
    endcase
  end

  assign mbus.m_rpay  = sbus.s_rpay;
  assign mbus.m_bresp = sbus.s_bresp;

  assign w_stateWrite = (r_state == ST_AW) || (r_state == ST_W) || (r_state == ST_B);
  assign status       = (r_state == ST_IDLE) ? 3'b000 : {1'b1, w_stateWrite, r_owner};

endmodule

// File: tb/tb_axi_txn_arbiter.sv
// Self-checking bench for axi_txn_arbiter: directed scenarios plus randomized
// transactions, checked against a transaction-level arbitration model.

module tb_axi_txn_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int AP = ADDR_W + 13;
  localparam int WP = DATA_W + 1;
  localparam int RP = DATA_W + 3;

  logic       aclk = 1'b0;
  logic       areset = 1'b0;
  logic [2:0] status;

  int nAssert = 0;
  int nFail = 0;

  // Transaction-level model: outstanding requests per master and arbitration history.
  bit [1:0]      pendAr;
  bit [1:0]      pendAw;
  logic [AP-1:0] arPay [2];
  logic [AP-1:0] awPay [2];
  int            lastWin;
  bit            prevWrite [2];

  axi_txn_m_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) mb ();
  axi_txn_s_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) sb ();

  axi_txn_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .aclk   (aclk),
    .areset (areset),
    .mbus   (mb),
    .sbus   (sb),
    .status (status)
  );

  always #5 aclk = ~aclk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nAssert++;
    assert (obs === exp) else begin
      nFail++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic applyStimulus();
    mb.m_arvalid = pendAr;
    mb.m_arpay   = {arPay[1], arPay[0]};
    mb.m_awvalid = pendAw;
    mb.m_awpay   = {awPay[1], awPay[0]};
  endtask

  function automatic logic [AP-1:0] makePay();
    logic [31:0] a;
    logic [7:0]  len;
    a   = $urandom();
    len = 8'($urandom_range(0, 15));
    return {a, len, 3'd2, 2'd1};
  endfunction

  task automatic modelReset();
    lastWin      = 1;
    prevWrite[0] = 1'b1;
    prevWrite[1] = 1'b1;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_handshake"},
                {mb.m_arready, mb.m_rvalid, mb.m_awready, mb.m_wready, mb.m_bvalid,
                 sb.s_arvalid, sb.s_rready, sb.s_awvalid, sb.s_wvalid, sb.s_bready}, 0);
    checkOutput({tag, "_spay"}, 64'(|{sb.s_arpay, sb.s_awpay, sb.s_wpay}), 0);
    checkOutput({tag, "_status"}, status, 0);
  endtask

  task automatic doReset(input string tag);
    areset = 1'b1;
    #1;
    checkAllZero(tag);
    #2;
    areset       = 1'b0;
    pendAr       = 2'b00;
    pendAw       = 2'b00;
    applyStimulus();
    mb.m_wvalid  = 2'b00;
    sb.s_rvalid  = 1'b0;
    sb.s_bvalid  = 1'b0;
    modelReset();
    tick();
  endtask

  // Runs one whole granted transaction; entered in an IDLE cycle with requests already driven.
  task automatic runTxn(input int nBeats, input bit lateReq);
    int            w;
    bit            isW;
    logic [1:0]    msk;
    logic [RP-1:0] rp;
    logic [WP-1:0] wp;
    logic [WP-1:0] junk;
    logic [1:0]    br;
    logic [31:0]   d;
    bit            lastBeat;
    bool_req: begin
      bit r0, r1;
      r0 = pendAr[0] | pendAw[0];
      r1 = pendAr[1] | pendAw[1];
      if (r0 && r1) w = 1 - lastWin;
      else if (r1)  w = 1;
      else          w = 0;
    end
    if (pendAr[w] && pendAw[w]) isW = !prevWrite[w];
    else                        isW = pendAw[w];
    msk = (w == 1) ? 2'b10 : 2'b01;
    mb.m_rready = msk;
    mb.m_bready = msk;

    #1;
    checkOutput("idle_status", status, 0);
    checkOutput("idle_svalid", {sb.s_arvalid, sb.s_awvalid}, 0);
    tick();

    if (!isW) begin
      if ($urandom_range(0, 2) == 0) begin
        sb.s_arready = 1'b0;
        #1;
        checkOutput("ar_stall_mready", mb.m_arready, 0);
        checkOutput("ar_stall_svalid", sb.s_arvalid, 1);
        tick();
        sb.s_arready = 1'b1;
      end
      #1;
      checkOutput("ar_status", status, {1'b1, 1'b0, w[0]});
      checkOutput("ar_svalid", sb.s_arvalid, 1);
      checkOutput("ar_spay", sb.s_arpay, arPay[w]);
      checkOutput("ar_mready", mb.m_arready, msk);
      checkOutput("ar_awvalid", sb.s_awvalid, 0);
      tick();
      pendAr[w] = 1'b0;
      applyStimulus();
      for (int b = 0; b < nBeats; b++) begin
        if ($urandom_range(0, 3) == 0) begin
          sb.s_rvalid = 1'b0;
          #1;
          checkOutput("r_stall_mvalid", mb.m_rvalid, 0);
          checkOutput("r_stall_status", status, {2'b10, w[0]});
          tick();
        end
        d        = $urandom();
        lastBeat = (b == nBeats - 1);
        rp       = {d, 2'($urandom()), lastBeat};
        sb.s_rvalid = 1'b1;
        sb.s_rpay   = rp;
        if (lateReq && b == 0) begin
          pendAr[1-w] = 1'b1;
          arPay[1-w]  = makePay();
          applyStimulus();
        end
        #1;
        checkOutput("r_mvalid", mb.m_rvalid, msk);
        checkOutput("r_sready", sb.s_rready, 1);
        checkOutput("r_mpay", mb.m_rpay, rp);
        checkOutput("r_status", status, {2'b10, w[0]});
        checkOutput("r_spay_zero", 64'(|{sb.s_arpay, sb.s_awpay, sb.s_wpay}), 0);
        tick();
      end
      sb.s_rvalid = 1'b0;
      sb.s_rpay   = '0;
    end else begin
      if ($urandom_range(0, 2) == 0) begin
        sb.s_awready = 1'b0;
        #1;
        checkOutput("aw_stall_mready", mb.m_awready, 0);
        checkOutput("aw_stall_svalid", sb.s_awvalid, 1);
        tick();
        sb.s_awready = 1'b1;
      end
      #1;
      checkOutput("aw_status", status, {1'b1, 1'b1, w[0]});
      checkOutput("aw_svalid", sb.s_awvalid, 1);
      checkOutput("aw_spay", sb.s_awpay, awPay[w]);
      checkOutput("aw_mready", mb.m_awready, msk);
      checkOutput("aw_arvalid", sb.s_arvalid, 0);
      tick();
      pendAw[w] = 1'b0;
      applyStimulus();
      for (int b = 0; b < nBeats; b++) begin
        if ($urandom_range(0, 3) == 0) begin
          mb.m_wvalid = 2'b00;
          #1;
          checkOutput("w_stall_svalid", sb.s_wvalid, 0);
          tick();
        end
        d        = $urandom();
        lastBeat = (b == nBeats - 1);
        wp       = {d, lastBeat};
        junk     = {32'($urandom()), 1'b1};
        mb.m_wvalid = msk;
        mb.m_wpay   = (w == 1) ? {wp, junk} : {junk, wp};
        if (lateReq && b == 0) begin
          pendAr[1-w] = 1'b1;
          arPay[1-w]  = makePay();
          applyStimulus();
        end
        #1;
        checkOutput("w_svalid", sb.s_wvalid, 1);
        checkOutput("w_spay", sb.s_wpay, wp);
        checkOutput("w_mready", mb.m_wready, msk);
        checkOutput("w_arready_lock", mb.m_arready, 0);
        checkOutput("w_status", status, {2'b11, w[0]});
        tick();
      end
      mb.m_wvalid = 2'b00;
      br          = 2'($urandom());
      sb.s_bvalid = 1'b1;
      sb.s_bresp  = br;
      #1;
      checkOutput("b_mvalid", mb.m_bvalid, msk);
      checkOutput("b_sready", sb.s_bready, 1);
      checkOutput("b_mresp", mb.m_bresp, br);
      checkOutput("b_arready_lock", mb.m_arready, 0);
      tick();
      sb.s_bvalid = 1'b0;
    end

    lastWin      = w;
    prevWrite[w] = isW;
  endtask

  initial begin
    pendAr       = 2'b00;
    pendAw       = 2'b00;
    arPay[0]     = '0;
    arPay[1]     = '0;
    awPay[0]     = '0;
    awPay[1]     = '0;
    applyStimulus();
    mb.m_rready  = 2'b00;
    mb.m_wvalid  = 2'b00;
    mb.m_wpay    = '0;
    mb.m_bready  = 2'b00;
    sb.s_arready = 1'b1;
    sb.s_awready = 1'b1;
    sb.s_wready  = 1'b1;
    sb.s_rvalid  = 1'b0;
    sb.s_rpay    = '0;
    sb.s_bvalid  = 1'b0;
    sb.s_bresp   = 2'b00;
    modelReset();
    #1;

    $display("[TB] reset, then M0 single read of 4 beats");
    doReset("reset0");
    arPay[0] = {32'd2, 8'd3, 3'd2, 2'd1};
    pendAr   = 2'b01;
    applyStimulus();
    runTxn(4, 1'b0);

    $display("[TB] reset, then M0 and M1 read tie");
    doReset("reset1");
    arPay[0] = makePay();
    arPay[1] = makePay();
    pendAr   = 2'b11;
    applyStimulus();
    runTxn(2, 1'b0);
    runTxn(3, 1'b0);

    $display("[TB] reset, then M1 read and write together, repeatedly");
    doReset("reset2");
    for (int k = 0; k < 4; k++) begin
      if (!pendAr[1]) arPay[1] = makePay();
      if (!pendAw[1]) awPay[1] = makePay();
      pendAr[1] = 1'b1;
      pendAw[1] = 1'b1;
      applyStimulus();
      runTxn($urandom_range(1, 3), 1'b0);
    end
    pendAr = 2'b00;
    pendAw = 2'b00;
    applyStimulus();

    $display("[TB] M0 write with M1 read arriving mid-burst");
    awPay[0] = {32'h100, 8'd1, 3'd2, 2'd1};
    pendAw   = 2'b01;
    applyStimulus();
    runTxn(2, 1'b1);
    runTxn(1, 1'b0);

    $display("[TB] reset during write data phase");
    awPay[0] = makePay();
    pendAw   = 2'b01;
    applyStimulus();
    tick();
    tick();
    pendAw = 2'b00;
    applyStimulus();
    mb.m_wvalid = 2'b01;
    mb.m_wpay   = {33'd0, 32'hA5A5_0001, 1'b0};
    tick();
    mb.m_wpay   = {33'd0, 32'hA5A5_0002, 1'b0};
    #1;
    checkOutput("pre_reset_status", status, 3'b110);
    doReset("mid_reset");
    arPay[0] = makePay();
    arPay[1] = makePay();
    pendAr   = 2'b11;
    applyStimulus();
    runTxn(1, 1'b0);
    runTxn(2, 1'b0);

    $display("[TB] randomized transactions");
    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < 2; i++) begin
        if (!pendAr[i] && !pendAw[i] && $urandom_range(0, 2) != 0) begin
          int r;
          r = $urandom_range(1, 3);
          pendAr[i] = r[0];
          pendAw[i] = r[1];
          arPay[i]  = makePay();
          awPay[i]  = makePay();
        end
      end
      if (pendAr == 2'b00 && pendAw == 2'b00) begin
        int k;
        k = $urandom_range(0, 1);
        pendAr[k] = 1'b1;
        arPay[k]  = makePay();
      end
      applyStimulus();
      runTxn($urandom_range(1, 4), $urandom_range(0, 5) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule

// File: doc/axi_txn_arbiter.md
# axi_txn_arbiter

Two-master to one-slave AXI transaction arbiter in front of the single-threaded AXI slave, which accepts one transaction at a time. It grants the shared slave to one master for a whole read or write transaction. Arbitration is round-robin across masters and alternates read/write within a master. All other channels are locked to the owner until the transaction completes.

## Interface
- ADDR_W, 32, address width; AP = ADDR_W+13 = {addr, len[7:0], size[2:0], burst[1:0]}
- DATA_W, 32, data width; lane i of every m_* vector belongs to master i (i = 0,1)
- aclk  in  1  clock, all logic on rising edge
- areset  in  1  asynchronous, active-high reset
- m_arvalid  in  2  read address valid per master
- m_arpay  in  2*AP  read address payload per master
- m_arready  out  2  read address ready per master
- m_rvalid  out  2  read data valid, owner lane only
- m_rpay  out  DATA_W+3  {rdata, rresp, rlast}, broadcast to both masters
- m_rready  in  2  read data ready per master
- m_awvalid  in  2  write address valid per master
- m_awpay  in  2*AP  write address payload per master
- m_awready  out  2  write address ready per master
- m_wvalid  in  2  write data valid per master
- m_wpay  in  2*(DATA_W+1)  {wdata, wlast} per master
- m_wready  out  2  write data ready per master
- m_bvalid  out  2  write response valid, owner lane only
- m_bresp  out  2  write response, broadcast
- m_bready  in  2  write response ready per master
- s_arvalid / s_arpay / s_arready  out / out / in  1 / AP / 1  read address channel to slave
- s_rvalid / s_rpay / s_rready  in / in / out  1 / DATA_W+3 / 1  read data channel from slave
- s_awvalid / s_awpay / s_awready  out / out / in  1 / AP / 1  write address channel to slave
- s_wvalid / s_wpay / s_wready  out / out / in  1 / DATA_W+1 / 1  write data channel to slave
- s_bvalid / s_bresp / s_bready  in / in / out  1 / 2 / 1  write response channel from slave
- status  out  3  {active, is_write, owner}

## Operation
- FSM states: IDLE, AR, R, AW, W, B.
  - IDLE→AR or AW when any request (m_arvalid | m_awvalid) is present.
  - AR→R on s_arvalid&&s_arready.
  - R→IDLE on s_rvalid&&s_rready&&rlast.
  - AW→W on s_awvalid&&s_awready.
  - W→B on s_wvalid&&s_wready&&wlast.
  - B→IDLE on s_bvalid&&s_bready.
- Master selection (registered in IDLE):
  - Only one master requesting: that master wins.
  - Both requesting: the master that did not win last wins.
  - Register `last` is updated at each grant.
- Direction selection for the winner:
  - Only arvalid or only awvalid set: that direction is taken.
  - Both set: direction is opposite to the winner's previous direction (per-master toggle bit; reset value = write, so read goes first).
- Routing:
  - In AR/AW/W, the s_* valid and payload equal the owner lane.
  - The owner's ready equals the slave's ready.
  - The non-owner's ready/valid outputs are 0.
  - s_*pay is 0 outside its channel state.
- Response routing:
  - In R, m_rvalid[owner] = s_rvalid and s_rready = m_rready[owner].
  - In B, m_bvalid[owner] = s_bvalid and s_bready = m_bready[owner].
  - m_rpay and m_bresp pass through unconditionally.
- Beat count: the transaction ends only on the rlast/wlast handshake; len is not counted.

## Timing
- Reset (async assert): state=IDLE, last=1 (master 0 wins the first tie), toggle bits=write.
  - All ready/valid outputs, s_*pay and status are 0 immediately.
- Reset mid-transaction aborts the transaction with no completion.
- Grant latency: a request seen in IDLE at edge N gives AR/AW state and s_*valid in cycle N+1.
- There is no combinational path from m_*valid to s_*valid while in IDLE.
- Back-to-back: the final handshake at edge N returns to IDLE.
  - The next grant is taken at edge N+1.
  - Minimum one dead cycle between transactions.
- New requests arriving during a transaction have no effect on the current owner.
- Requests are sampled only in IDLE.
- status updates on the same edge as the state change; active=0 in IDLE.

## Test plan
- Reset, then M0 only issues read (araddr=2, len=3), slave returns 4 beats → s_arvalid high in cycle 1 after request, M0 gets 4 m_rvalid beats, rlast on 4th, M1 lanes stay 0, status=3'b100.
- M0 and M1 both assert arvalid in the same cycle after reset → M0 served first, M1 granted one cycle after M0's rlast handshake, status owner 0 then 1.
- M1 asserts arvalid and awvalid together, repeatedly → read granted first, then write (AW, W beats until wlast, B), alternating thereafter.
- M0 write (len=1, 2 beats, wlast on 2nd) while M1 raises arvalid mid-burst → M1 stays ungranted (m_arready[1]=0) until M0's bvalid&&bready, then granted.
- areset asserted while in W after 1 of 4 beats → all outputs 0 in the same cycle; after release, state IDLE and master 0 wins the next tie.
